ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage for the MSP430 core model, sitting directly upstream of the program ROM. It drives the ROM's 16-bit byte address, captures the combinationally returned instruction word, and buffers fetched words with their addresses in a small queue for the decoder. On reset it loads the PC from the reset vector, and on a redirect it flushes the queue and restarts fetching at a new address.

## Interface
- `RESET_VECTOR`, 16'hFFFE: ROM address of the reset vector word.
- `DEPTH`, 2: fetch queue entries; power of two, 2..8.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rom_addr`  out  16: byte address to ROM; always even.
- `rom_data`  in  16: ROM word at `rom_addr`, combinational, same cycle.
- `redirect_valid`  in  1: branch/jump/interrupt redirect request.
- `redirect_pc`  in  16: redirect target byte address.
- `iq_valid`  out  1: queue head holds a word.
- `iq_ready`  in  1: decoder accepts head; pop when `iq_valid & iq_ready`.
- `iq_data`  out  16: head instruction/extension word.
- `iq_pc`  out  16: byte address the head word was fetched from.
- `fetch_pc`  out  16: current PC register (next address to fetch).
- `fault`  out  1: misaligned redirect flag (see Configuration).

## Operation
- States: `S_VEC` and `S_RUN`. Reset enters `S_VEC`.
- `S_VEC`: `rom_addr = RESET_VECTOR`. On the next edge, PC <= `rom_data & 16'hFFFE`, state -> `S_RUN`. `redirect_valid` is ignored in `S_VEC`. No push occurs.
- `S_RUN`: `rom_addr = PC`. Push condition: `!redirect_valid && (count < DEPTH || pop)`. On a push, the entry {PC, `rom_data`} is written and PC <= PC + 2, mod 2^16 (16'hFFFE wraps to 16'h0000). With no push, PC holds.
- Full with simultaneous pop: the push is allowed, and count is unchanged.
- Redirect in `S_RUN` (highest priority): the queue is cleared (count <= 0), including any same-cycle pop. PC <= `redirect_pc` with bit 0 cleared. No push that cycle.
- Empty queue: `iq_valid = 0`, and `iq_data`/`iq_pc` are don't-care. Pop while empty has no effect.
- Queue is FIFO order. Head outputs are registered entries, not combinational from `rom_data`.
- Reset mid-operation: immediate return to `S_VEC` with an empty queue, regardless of pending redirect or pop.
- Reset values: PC = 16'h0000, count = 0, `iq_valid = 0`, `fault = 0`, state `S_VEC`, `rom_addr = RESET_VECTOR`, `fetch_pc = 16'h0000`.

## Timing
- Reset release: cycle 0 is `S_VEC` (vector read). Cycle 1 has `rom_addr` = vector contents, and the first push happens at the end of cycle 1. `iq_valid` rises in cycle 2.
- Redirect asserted in cycle n: `rom_addr = redirect_pc` in n+1, and `iq_valid` is high in n+2 with `iq_pc = redirect_pc`.
- Steady state with `iq_ready` held high: one word per cycle, consecutive `iq_pc` values differ by 2.
- `rom_addr` is combinational from the state and PC registers only. It never depends on `iq_ready` or `redirect_valid`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect, or a reset vector, with bit 0 = 1 sets `fault` on the next edge.
  - `fault` is sticky until reset.
  - The fetch still proceeds at the address with bit 0 cleared.
- `IFETCH_ALIGN_CHECK_EN` undefined:
  - `fault` is tied to 0.
  - Bit 0 is silently cleared.

## Structure
- Package `ifetch_pkg`:
  - state enum (`S_VEC`, `S_RUN`)
  - `WORD_W = 16`
  - `PC_INC = 2`
  - default `RESET_VECTOR`
- Sub-module `ifetch_queue`: DEPTH-entry FIFO of {pc, data} with push, pop, flush, count, valid and full. The PC/FSM logic stays in `ifetch`.

## Test plan
- Vector word 16'hC000 at 16'hFFFE, `iq_ready = 1`: cycle 1 `rom_addr = 16'hC000`; cycle 2 `iq_valid = 1`, `iq_pc = 16'hC000`; cycle 3 `iq_pc = 16'hC002`.
- `iq_ready = 0` after start: exactly 2 pushes (`DEPTH = 2`) and `fetch_pc = 16'hC004`, then it holds. Release `iq_ready`: words C000, C002, C004 come out in order with no gap.
- Redirect to 16'hC100 while full and popping: queue flushed, next `iq_pc = 16'hC100` two cycles later, and the popped-that-cycle state is irrelevant.
- PC at 16'hFFFE with a push: next `fetch_pc = 16'h0000`.
- Redirect to 16'hC101: `rom_addr = 16'hC100`. `fault = 1` with `IFETCH_ALIGN_CHECK_EN`, `fault = 0` without.
- Assert `rst_n` low mid-stream with the queue full: `iq_valid` is 0 immediately and `rom_addr = 16'hFFFE`, and the vector reload sequence repeats after release.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the MSP430 instruction fetch stage.
//   state_t    : fetch FSM states (S_VEC reads the reset vector, S_RUN streams words)
//   iq_entry_t : one fetch queue entry {pc, data}
//   align_pc   : clears bit 0 of a byte address so the ROM only sees word addresses
package ifetch_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned PC_INC = 2;

   localparam logic [WORD_W-1:0] DEFAULT_RESET_VECTOR = 16'hFFFE;

   typedef enum logic {
      S_VEC = 1'b0,
      S_RUN = 1'b1
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] data;
   } iq_entry_t;

   // Word-align a byte address.
   function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry FIFO of fetched {pc, data} words feeding the decoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_entry at the tail (ignored when full without a pop)
//   pop        : drop the head (ignored when empty)
//   flush      : empty the queue; wins over push and pop in the same cycle
//   wr_entry   : entry to write
//   head       : registered head entry, meaningful only while valid
//   count      : number of held entries (0..DEPTH)
//   valid      : queue is non-empty
//   full       : count == DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  iq_entry_t                  wr_entry,
   output iq_entry_t                  head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       valid,
   output logic                       full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   iq_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   // Status flags come straight from the registered count.
   assign valid = (count != '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A full queue accepts a push only when the head leaves in the same cycle.
   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);

   assign head = mem[rd_ptr];

   // Entry storage; no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/ifetch.sv
// ifetch: MSP430 instruction fetch stage in front of the program ROM.
//   RESET_VECTOR   : ROM address of the reset vector word
//   DEPTH          : fetch queue entries (power of two, 2..8)
//   clk, rst_n     : clock, asynchronous active-low reset
//   rom_addr       : ROM byte address (always even, combinational from state/PC)
//   rom_data       : ROM word at rom_addr, returned in the same cycle
//   redirect_valid : branch/jump/interrupt redirect request
//   redirect_pc    : redirect target byte address
//   iq_valid       : queue head holds a word
//   iq_ready       : decoder takes the head this cycle
//   iq_data        : head instruction/extension word
//   iq_pc          : byte address the head word came from
//   fetch_pc       : PC register (next address to fetch)
//   fault          : sticky misaligned-target flag
// Build option IFETCH_ALIGN_CHECK_EN: when defined, an odd redirect target or
// odd reset vector sets fault until reset; otherwise fault is tied low. In both
// builds the fetch continues at the target with bit 0 cleared.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned       DEPTH        = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [WORD_W-1:0] rom_addr,
   input  logic [WORD_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              iq_valid,
   input  logic              iq_ready,
   output logic [WORD_W-1:0] iq_data,
   output logic [WORD_W-1:0] iq_pc,
   output logic [WORD_W-1:0] fetch_pc,
   output logic              fault
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_t            state;
   state_t            state_nxt;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_nxt;

   logic              load_vec;
   logic              load_redir;
   logic              push;
   logic              pop;
   logic              flush;

   iq_entry_t         q_wr;
   iq_entry_t         q_head;
   logic [CNT_W-1:0]  q_count;
   logic              q_valid;
   logic              q_full;

   assign pop = iq_ready & q_valid;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_VEC;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: one vector read, then fetch forever until reset.
   always_comb begin
      state_nxt = state;
      case (state)
         S_VEC:   state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_VEC;
      endcase
   end

   // FSM outputs: ROM address and the PC/queue control strobes.
   // A redirect beats both push and pop; the fetched word of that cycle is dropped.
   always_comb begin
      rom_addr   = align_pc(RESET_VECTOR);
      load_vec   = 1'b0;
      load_redir = 1'b0;
      push       = 1'b0;
      flush      = 1'b0;
      case (state)
         S_VEC: begin
            load_vec = 1'b1;
         end
         S_RUN: begin
            rom_addr = pc;
            if (redirect_valid) begin
               load_redir = 1'b1;
               flush      = 1'b1;
            end else if (!q_full || pop) begin
               push = 1'b1;
            end
         end
         default: begin
            load_vec = 1'b0;
         end
      endcase
   end

   // Next PC: vector load, redirect, or sequential advance (wraps mod 2^16).
   always_comb begin
      pc_nxt = pc;
      if (load_vec) begin
         pc_nxt = align_pc(rom_data);
      end else if (load_redir) begin
         pc_nxt = align_pc(redirect_pc);
      end else if (push) begin
         pc_nxt = pc + WORD_W'(PC_INC);
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else begin
         pc <= pc_nxt;
      end
   end

   assign fetch_pc = pc;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic fault_q;
   logic odd_target;

   assign odd_target = (load_vec & rom_data[0]) | (load_redir & redirect_pc[0]);

   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (odd_target) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign q_wr = '{pc: pc, data: rom_data};

   ifetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .wr_entry (q_wr),
      .head     (q_head),
      .count    (q_count),
      .valid    (q_valid),
      .full     (q_full)
   );

   assign iq_valid = q_valid;
   assign iq_data  = q_head.data;
   assign iq_pc    = q_head.pc;

   // Occupancy can never exceed the queue size.
   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      q_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch with a combinational ROM model and
// a scoreboard of expected fetch addresses; data expectations come from the ROM model.
module tb_ifetch;

`ifdef IFETCH_ALIGN_CHECK_EN
   localparam bit EXP_FAULT = 1'b1;
`else
   localparam bit EXP_FAULT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        iq_valid;
   logic        iq_ready;
   logic [15:0] iq_data;
   logic [15:0] iq_pc;
   logic [15:0] fetch_pc;
   logic        fault;

   logic [15:0] vec_word;
   logic [15:0] exp_q [$];
   logic [15:0] e;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // ROM: vector word at 16'hFFFE, an address-derived pattern elsewhere.
   assign rom_data = (rom_addr == 16'hFFFE) ? vec_word : (rom_addr ^ 16'hA5C3);

   function automatic logic [15:0] exp_word(input logic [15:0] a);
      return (a == 16'hFFFE) ? vec_word : (a ^ 16'hA5C3);
   endfunction

   ifetch #(
      .RESET_VECTOR (16'hFFFE),
      .DEPTH        (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .iq_valid       (iq_valid),
      .iq_ready       (iq_ready),
      .iq_data        (iq_data),
      .iq_pc          (iq_pc),
      .fetch_pc       (fetch_pc),
      .fault          (fault)
   );

   task automatic sb_fill(input logic [15:0] base, input int n);
      logic [15:0] a;
      a = base;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(a);
         a = a + 16'd2;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
      iq_ready = 1'b1; vec_word = 16'hC000;
      repeat (2) @(negedge clk);
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL reset_iq_valid: got %b want 0", iq_valid); end
      checks++; if (rom_addr !== 16'hFFFE) begin errors++; $display("FAIL reset_rom_addr: got %h want fffe", rom_addr); end
      checks++; if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL reset_fetch_pc: got %h want 0000", fetch_pc); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
   endtask

   task automatic test_startup();
      rst_n = 1'b1;                                 // cycle 0
      #1;
      checks++; if (rom_addr !== 16'hFFFE) begin errors++; $display("FAIL start_c0_rom_addr: got %h want fffe", rom_addr); end
      sb_fill(16'hC000, 8);
      @(negedge clk);                               // cycle 1
      checks++; if (rom_addr !== 16'hC000) begin errors++; $display("FAIL start_c1_rom_addr: got %h want c000", rom_addr); end
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL start_c1_iq_valid: got %b want 0", iq_valid); end
      @(negedge clk);                               // cycle 2 onwards: stream
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL start_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL start_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL start_drain: %0d words left want 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      rst_n = 1'b0; iq_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (fetch_pc !== 16'hC004) begin errors++; $display("FAIL bp_fetch_pc: got %h want c004", fetch_pc); end
      checks++; if (iq_valid !== 1'b1 || iq_pc !== 16'hC000) begin errors++; $display("FAIL bp_head: valid=%b pc=%h want 1 c000", iq_valid, iq_pc); end
      repeat (3) @(negedge clk);
      checks++; if (fetch_pc !== 16'hC004) begin errors++; $display("FAIL bp_hold: got %h want c004", fetch_pc); end
      iq_ready = 1'b1;
      sb_fill(16'hC000, 4);
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL bp_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL bp_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left want 0", exp_q.size()); end
   endtask

   task automatic test_redirect();
      iq_ready = 1'b0;
      repeat (3) @(negedge clk);                    // queue full
      iq_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'hC100;   // cycle n
      sb_fill(16'hC100, 4);
      @(negedge clk);                               // n+1
      redirect_valid = 1'b0;
      checks++; if (rom_addr !== 16'hC100) begin errors++; $display("FAIL redir_rom_addr: got %h want c100", rom_addr); end
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: iq_valid=%b want 0", iq_valid); end
      @(negedge clk);                               // n+2
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL redir_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL redir_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain: %0d words left want 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      iq_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'hFFFC;   // cycle n
      sb_fill(16'hFFFC, 4);
      @(negedge clk);                               // n+1
      redirect_valid = 1'b0;
      checks++; if (fetch_pc !== 16'hFFFC) begin errors++; $display("FAIL wrap_pc0: got %h want fffc", fetch_pc); end
      @(negedge clk);                               // n+2
      checks++; if (fetch_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc1: got %h want fffe", fetch_pc); end
      repeat (2) @(negedge clk);                    // full, holding
      checks++; if (fetch_pc !== 16'h0000 || rom_addr !== 16'h0000) begin errors++; $display("FAIL wrap_pc2: pc=%h addr=%h want 0000 0000", fetch_pc, rom_addr); end
      iq_ready = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL wrap_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL wrap_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d words left want 0", exp_q.size()); end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_pc = 16'hC101;                    // cycle n
      sb_fill(16'hC100, 3);
      @(negedge clk);                               // n+1
      redirect_valid = 1'b0;
      checks++; if (rom_addr !== 16'hC100) begin errors++; $display("FAIL mis_rom_addr: got %h want c100", rom_addr); end
      checks++; if (fault !== EXP_FAULT) begin errors++; $display("FAIL mis_fault: got %b want %b", fault, EXP_FAULT); end
      @(negedge clk);
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL mis_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL mis_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mis_drain: %0d words left want 0", exp_q.size()); end
      checks++; if (fault !== EXP_FAULT) begin errors++; $display("FAIL mis_sticky: got %b want %b", fault, EXP_FAULT); end
   endtask

   task automatic test_reset_midstream();
      iq_ready = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (iq_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_full: iq_valid=%b want 1", iq_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL rmid_iq_valid: got %b want 0", iq_valid); end
      checks++; if (rom_addr !== 16'hFFFE) begin errors++; $display("FAIL rmid_rom_addr: got %h want fffe", rom_addr); end
      checks++; if (fetch_pc !== 16'h0000 || fault !== 1'b0) begin errors++; $display("FAIL rmid_regs: pc=%h fault=%b want 0000 0", fetch_pc, fault); end
      // Odd vector, and a redirect held during the vector read that must be ignored.
      vec_word = 16'hD001; redirect_valid = 1'b1; redirect_pc = 16'h1234; iq_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;                                 // cycle 0
      #1;
      checks++; if (rom_addr !== 16'hFFFE) begin errors++; $display("FAIL rmid_c0_rom_addr: got %h want fffe", rom_addr); end
      sb_fill(16'hD000, 4);
      @(negedge clk);                               // cycle 1
      redirect_valid = 1'b0;
      checks++; if (rom_addr !== 16'hD000) begin errors++; $display("FAIL rmid_c1_rom_addr: got %h want d000", rom_addr); end
      checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL rmid_c1_iq_valid: got %b want 0", iq_valid); end
      checks++; if (fault !== EXP_FAULT) begin errors++; $display("FAIL rmid_vec_fault: got %b want %b", fault, EXP_FAULT); end
      @(negedge clk);                               // cycle 2
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         checks++;
         if (iq_valid !== 1'b1) begin errors++; $display("FAIL rmid_stream_gap: iq_valid=%b want 1", iq_valid); end
         else begin
            e = exp_q.pop_front(); checks++;
            if (iq_pc !== e || iq_data !== exp_word(e)) begin errors++; $display("FAIL rmid_order: pc=%h data=%h want pc=%h data=%h", iq_pc, iq_data, e, exp_word(e)); end
         end
         @(negedge clk);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drain: %0d words left want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_misalign();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop if the sequence above ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
